rv_reg_file: RTL and testbench

- Integer register file for the RISC-V core: 2 combinational read ports (rs1, rs2) and 1 synchronous write port (rd).
- Default configuration is 32 x 64-bit (RV64I).
- Register x0 is hardwired to zero.
- Sits in the decode stage, feeding the operand muxes and receiving writeback data.

---
 rtl/rv_reg_file_pkg.sv | 16 +
 rtl/rv_reg_file_if.sv | 23 ++
 rtl/rv_reg_file_read_port.sv | 36 +++
 rtl/rv_reg_file.sv | 49 ++++
 tb/tb_rv_reg_file.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/rv_reg_file_pkg.sv
// Shared widths, index/data types and constants for the integer register file.
package rv_reg_pkg;

  localparam int REG_DATA_WIDTH_POW = 6;
  localparam int REG_MEM_DEPTH_POW  = 5;
  localparam int REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW;
  localparam int REG_MEM_DEPTH      = 1 << REG_MEM_DEPTH_POW;
  localparam int NUM_READ_PORTS     = 2;

  typedef logic [REG_MEM_DEPTH_POW-1:0] reg_idx_t;
  typedef logic [REG_DATA_WIDTH-1:0]    reg_data_t;

  localparam reg_data_t ZERO_REG = '0;
  localparam reg_idx_t  ZERO_IDX = '0;

endpackage

// File: rtl/rv_reg_file_if.sv
// Decode-stage register file bus: two read indices, one write port, two read data lanes.
interface rv_reg_file_if;
  import rv_reg_pkg::*;

  reg_idx_t  rs1_in;
  reg_idx_t  rs2_in;
  reg_idx_t  rd_in;
  reg_data_t data_write;
  logic      write_en;
  reg_data_t reg_data1_out;
  reg_data_t reg_data2_out;

  modport master (
    output rs1_in, rs2_in, rd_in, data_write, write_en,
    input  reg_data1_out, reg_data2_out
  );

  modport slave (
    input  rs1_in, rs2_in, rd_in, data_write, write_en,
    output reg_data1_out, reg_data2_out
  );

endinterface

// File: rtl/rv_reg_file_read_port.sv
// One combinational read lane: x0 masking plus optional same-cycle write bypass
// (enabled by RV_REG_FILE_WRITE_BYPASS_EN).
module rv_reg_read_port
  import rv_reg_pkg::*;
(
  input  logic      rst_n_i,
  input  reg_idx_t  rs_idx_i,
  input  reg_data_t mem_i [REG_MEM_DEPTH],
  input  logic      write_en_i,
  input  reg_idx_t  rd_idx_i,
  input  reg_data_t data_write_i,
  output reg_data_t rdata_o
);

`ifdef RV_REG_FILE_WRITE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic bypass_hit;

  // Forwarding is never allowed to leak writeback data while the core is held in reset.
  assign bypass_hit = BYPASS_EN && rst_n_i && write_en_i &&
                      (rd_idx_i != ZERO_IDX) && (rd_idx_i == rs_idx_i);

  always_comb begin
    rdata_o = mem_i[rs_idx_i];
    if (!rst_n_i || (rs_idx_i == ZERO_IDX)) begin
      rdata_o = ZERO_REG;
    end else if (bypass_hit) begin
      rdata_o = data_write_i;
    end
  end

endmodule

// File: rtl/rv_reg_file.sv
// RV64I integer register file: 32 x 64-bit, two combinational reads, one synchronous write,
// x0 hardwired to zero. Optional write bypass via RV_REG_FILE_WRITE_BYPASS_EN.
module rv_reg_file
  import rv_reg_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  rv_reg_file_if.slave bus
);

  reg_data_t mem_q [REG_MEM_DEPTH];
  logic      wr_hit_d;
  reg_idx_t  rs_idx   [NUM_READ_PORTS];
  reg_data_t rd_data  [NUM_READ_PORTS];

  assign wr_hit_d = bus.write_en && (bus.rd_in != ZERO_IDX);

  // Entry 0 is reset and never written, so storage and masking agree on x0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_MEM_DEPTH; i++) begin
        mem_q[i] <= ZERO_REG;
      end
    end else if (wr_hit_d) begin
      mem_q[bus.rd_in] <= bus.data_write;
    end
  end

  assign rs_idx[0] = bus.rs1_in;
  assign rs_idx[1] = bus.rs2_in;

  generate
    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read_port
      rv_reg_read_port u_read_port (
        .rst_n_i      (rst_n_in),
        .rs_idx_i     (rs_idx[gi]),
        .mem_i        (mem_q),
        .write_en_i   (bus.write_en),
        .rd_idx_i     (bus.rd_in),
        .data_write_i (bus.data_write),
        .rdata_o      (rd_data[gi])
      );
    end
  endgenerate

  assign bus.reg_data1_out = rd_data[0];
  assign bus.reg_data2_out = rd_data[1];

endmodule

// File: tb/tb_rv_reg_file.sv
// Directed, table-driven bench for rv_reg_file with hand-written reset/collision sequences.
module tb_rv_reg_file;
  import rv_reg_pkg::*;

  logic clk_in;
  logic rst_n_in;
  int   checks;
  int   errors;

  rv_reg_file_if bus ();

  rv_reg_file dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  typedef struct {
    logic      we;
    reg_idx_t  rd;
    reg_data_t wd;
    reg_idx_t  rs1;
    reg_idx_t  rs2;
    reg_data_t e1;
    reg_data_t e2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input reg_data_t act, input reg_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input reg_idx_t rd, input reg_data_t wd,
                       input reg_idx_t rs1, input reg_idx_t rs2);
    bus.write_en   = we;
    bus.rd_in      = rd;
    bus.data_write = wd;
    bus.rs1_in     = rs1;
    bus.rs2_in     = rs2;
  endtask

  initial begin
    reg_data_t exp_pre;
    checks = 0;
    errors = 0;

    // Expected outputs are the state before the edge that follows each vector.
    vecs[0] = '{1'b1, 5'd3,  64'hDEAD_BEEF_0123_4567, 5'd5,  5'd31, 64'h0, 64'h0};
    vecs[1] = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd3,  5'd3,
                64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{1'b1, 5'd7,  64'h1111, 5'd0, 5'd3, 64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[3] = '{1'b0, 5'd7,  64'h2222, 5'd7, 5'd0, 64'h1111, 64'h0};
    vecs[4] = '{1'b1, 5'd31, 64'hA5A5_5A5A_0F0F_F0F0, 5'd7, 5'd0, 64'h1111, 64'h0};
    vecs[5] = '{1'b0, 5'd0,  64'h0, 5'd31, 5'd31, 64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[6] = '{1'b1, 5'd1,  64'h1, 5'd0, 5'd7, 64'h0, 64'h1111};
    vecs[7] = '{1'b0, 5'd0,  64'h0, 5'd1, 5'd31, 64'h1, 64'hA5A5_5A5A_0F0F_F0F0};

    // Reset held from time zero.
    rst_n_in = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd31);
    #2;
    chk("reset_rs1_5", bus.reg_data1_out, ZERO_REG);
    chk("reset_rs2_31", bus.reg_data2_out, ZERO_REG);
    $display("txn reset: rs1=5 rs2=31 d1=%h d2=%h", bus.reg_data1_out, bus.reg_data2_out);

    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < REG_MEM_DEPTH; i++) begin
      bus.rs1_in = reg_idx_t'(i);
      bus.rs2_in = reg_idx_t'(REG_MEM_DEPTH - 1 - i);
      #1;
      chk($sformatf("post_reset_rs1_%0d", i), bus.reg_data1_out, ZERO_REG);
      chk($sformatf("post_reset_rs2_%0d", REG_MEM_DEPTH - 1 - i), bus.reg_data2_out, ZERO_REG);
    end
    $display("txn post_reset sweep of %0d indices", REG_MEM_DEPTH);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk_in);
      drive(vecs[v].we, vecs[v].rd, vecs[v].wd, vecs[v].rs1, vecs[v].rs2);
      #2;
      chk($sformatf("vec%0d_d1", v), bus.reg_data1_out, vecs[v].e1);
      chk($sformatf("vec%0d_d2", v), bus.reg_data2_out, vecs[v].e2);
      $display("txn vec%0d: we=%b rd=%0d wd=%h rs1=%0d rs2=%0d d1=%h d2=%h", v, vecs[v].we,
               vecs[v].rd, vecs[v].wd, vecs[v].rs1, vecs[v].rs2,
               bus.reg_data1_out, bus.reg_data2_out);
    end

    // x0 write attempt must not show even as a same-cycle forward.
    @(negedge clk_in);
    drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    #2;
    chk("x0_same_cycle", bus.reg_data1_out, ZERO_REG);
    @(negedge clk_in);
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #2;
    chk("x0_after_edge", bus.reg_data1_out, ZERO_REG);
    $display("txn x0_write: d1=%h", bus.reg_data1_out);

    // Same-cycle collision on x9.
    @(negedge clk_in);
    drive(1'b1, 5'd9, 64'hA, 5'd0, 5'd0);
    @(negedge clk_in);
    drive(1'b1, 5'd9, 64'hB, 5'd9, 5'd9);
`ifdef RV_REG_FILE_WRITE_BYPASS_EN
    exp_pre = 64'hB;
`else
    exp_pre = 64'hA;
`endif
    #2;
    chk("collision_pre_d1", bus.reg_data1_out, exp_pre);
    chk("collision_pre_d2", bus.reg_data2_out, exp_pre);
    @(negedge clk_in);
    drive(1'b0, 5'd9, 64'h0, 5'd9, 5'd9);
    #2;
    chk("collision_post_d1", bus.reg_data1_out, 64'hB);
    chk("collision_post_d2", bus.reg_data2_out, 64'hB);
    $display("txn collision x9: pre=%h post=%h", exp_pre, bus.reg_data1_out);

    // Asynchronous reset between edges.
    @(negedge clk_in);
    drive(1'b1, 5'd12, 64'h55, 5'd0, 5'd0);
    @(negedge clk_in);
    drive(1'b0, 5'd0, 64'h0, 5'd12, 5'd12);
    #2;
    chk("x12_written", bus.reg_data1_out, 64'h55);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_reset_d1", bus.reg_data1_out, ZERO_REG);
    chk("async_reset_d2", bus.reg_data2_out, ZERO_REG);
    @(negedge clk_in);
    drive(1'b1, 5'd12, 64'h77, 5'd12, 5'd12);
    #2;
    chk("reset_no_bypass_d1", bus.reg_data1_out, ZERO_REG);
    chk("reset_no_bypass_d2", bus.reg_data2_out, ZERO_REG);
    @(negedge clk_in);
    drive(1'b0, 5'd0, 64'h0, 5'd12, 5'd9);
    rst_n_in = 1'b1;
    #2;
    chk("reset_wins_x12", bus.reg_data1_out, ZERO_REG);
    chk("reset_cleared_x9", bus.reg_data2_out, ZERO_REG);
    $display("txn async_reset x12: d1=%h", bus.reg_data1_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
